// File: rtl/instruction_rom_responder_pkg.sv
// Shared definitions for the instruction-fetch responder and its byte packer.
package instruction_rom_responder_pkg;

  localparam int INSTR_WIDTH      = 40;
  localparam int BYTES_PER_INSTR  = 5;
  localparam int BYTE_COUNT_WIDTH = 3;

  localparam logic [INSTR_WIDTH-1:0] FAULT_WORD = '0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE,
    FAULT
  } fetchState_e;

endpackage

// File: rtl/instruction_rom_responder_byte_packer.sv
// Byte-serial assembler: shifts bytes in MSB-first and presents the full word
// combinationally together with the byte currently on dataIn.
module instruction_byte_packer
  import instruction_rom_responder_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        shiftEnable,
  input  logic [7:0]                  dataIn,
  output logic [INSTR_WIDTH-1:0]      assembledWord,
  output logic [BYTE_COUNT_WIDTH-1:0] byteCount
);

  // Only the first four bytes need storage; the last byte is taken straight
  // from dataIn in the cycle it arrives, so the word is ready without a bubble.
  logic [INSTR_WIDTH-9:0] heldBytes;

  // Shift register and byte counter (saturates at BYTES_PER_INSTR)
  always_ff @(posedge clk) begin
    if (!reset) begin
      heldBytes <= '0;
      byteCount <= '0;
    end else if (clear) begin
      heldBytes <= '0;
      byteCount <= '0;
    end else if (shiftEnable) begin
      heldBytes <= {heldBytes[INSTR_WIDTH-17:0], dataIn};
      if (byteCount != BYTE_COUNT_WIDTH'(BYTES_PER_INSTR))
        byteCount <= byteCount + 1'b1;
    end
  end

  // Word as it will look once the byte on dataIn is captured
  always_comb begin
    assembledWord = {heldBytes, dataIn};
  end

endmodule

// File: rtl/instruction_rom_responder.sv
// Memory-side responder for the MCU instruction fetch: reads five bytes from a
// byte-wide synchronous program store and returns one 40-bit instruction.
module instruction_rom_responder
  import instruction_rom_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int ROM_WORDS  = 4096,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instructionAddress,
  input  logic                   readInstructionStarting,
  output logic [INSTR_WIDTH-1:0] instructionBuffer,
  output logic                   readInstructionCompleting,
  output logic                   readInstructionComplete,
  output logic                   busy,
  output logic                   outOfRange,
  output logic                   requestDropped,
  output logic [ADDR_WIDTH-1:0]  memAddress,
  output logic                   memReadEnable,
  input  logic [7:0]             memData
);

  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 32) begin : gWidthCheck
    $error("instruction_rom_responder: ADDR_WIDTH must be in 3..32");
  end
  if (longint'(BASE_ADDR) + 5 * longint'(ROM_WORDS) > (longint'(1) << ADDR_WIDTH)) begin : gRangeCheck
    $error("instruction_rom_responder: program store does not fit the address space");
  end

  fetchState_e state, stateNext;

  logic                        accept;
  logic                        indexValid;
  logic [ADDR_WIDTH-1:0]       indexLow;
  logic [ADDR_WIDTH-1:0]       startAddress;
  logic [BYTE_COUNT_WIDTH-1:0] issueCount;
  logic                        readValid;
  logic                        faultFlag;
  logic [INSTR_WIDTH-1:0]      assembledWord;
  logic [BYTE_COUNT_WIDTH-1:0] byteCount;

  // Request decode: range check on the full index, byte address as base + 5*index
  always_comb begin
    accept       = readInstructionStarting && (state == IDLE || state == DONE);
    indexValid   = instructionAddress < 32'(ROM_WORDS);
    indexLow     = instructionAddress[ADDR_WIDTH-1:0];
    startAddress = ADDR_WIDTH'(BASE_ADDR) + (indexLow << 2) + indexLow;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    stateNext = IDLE;
      ISSUE:   if (issueCount == BYTE_COUNT_WIDTH'(BYTES_PER_INSTR - 1)) stateNext = DRAIN;
      DRAIN:   stateNext = DONE;
      FAULT:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (accept) stateNext = indexValid ? ISSUE : FAULT;
  end

  // Status strobes decoded from state
  always_comb begin
    busy                      = (state == ISSUE) || (state == DRAIN) || (state == FAULT);
    readInstructionCompleting = (state == DRAIN) &&
                                (byteCount == BYTE_COUNT_WIDTH'(BYTES_PER_INSTR - 1));
    readInstructionComplete   = (state == DONE);
    outOfRange                = (state == DONE) && faultFlag;
  end

  // Address generator, read strobe, capture pipeline and result register
  always_ff @(posedge clk) begin
    if (!reset) begin
      memAddress        <= '0;
      memReadEnable     <= 1'b0;
      issueCount        <= '0;
      readValid         <= 1'b0;
      faultFlag         <= 1'b0;
      requestDropped    <= 1'b0;
      instructionBuffer <= '0;
    end else begin
      requestDropped <= readInstructionStarting && busy;
      readValid      <= memReadEnable;
      if (accept) begin
        faultFlag     <= !indexValid;
        issueCount    <= '0;
        memReadEnable <= indexValid;
        if (indexValid) memAddress <= startAddress;
      end else if (state == ISSUE) begin
        if (issueCount == BYTE_COUNT_WIDTH'(BYTES_PER_INSTR - 1)) begin
          memReadEnable <= 1'b0;
        end else begin
          memAddress <= memAddress + 1'b1;
          issueCount <= issueCount + 1'b1;
        end
      end
      if (state == DRAIN) instructionBuffer <= assembledWord;
      if (state == FAULT) instructionBuffer <= FAULT_WORD;
    end
  end

  instruction_byte_packer uPacker (
    .clk           (clk),
    .reset         (reset),
    .clear         (accept),
    .shiftEnable   (readValid),
    .dataIn        (memData),
    .assembledWord (assembledWord),
    .byteCount     (byteCount)
  );

endmodule

// File: tb/tb_instruction_rom_responder.sv
// Directed bench for instruction_rom_responder with a behavioural program store.
module tb_instruction_rom_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instructionAddress;
  logic        readInstructionStarting;
  logic [39:0] instructionBuffer;
  logic        readInstructionCompleting;
  logic        readInstructionComplete;
  logic        busy;
  logic        outOfRange;
  logic        requestDropped;
  logic [15:0] memAddress;
  logic        memReadEnable;
  logic [7:0]  memData;

  // second instance placed at the top of the address space
  logic [31:0] bInstructionAddress;
  logic        bReadInstructionStarting;
  logic [39:0] bInstructionBuffer;
  logic        bReadInstructionCompleting;
  logic        bReadInstructionComplete;
  logic        bBusy;
  logic        bOutOfRange;
  logic        bRequestDropped;
  logic [15:0] bMemAddress;
  logic        bMemReadEnable;
  logic [7:0]  bMemData;

  logic [7:0] rom [0:65535];
  int checks   = 0;
  int failures = 0;
  int completeCount = 0;

  always #5 clk = ~clk;

  instruction_rom_responder #(.ADDR_WIDTH(16), .ROM_WORDS(4096), .BASE_ADDR(0)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .instructionAddress        (instructionAddress),
    .readInstructionStarting   (readInstructionStarting),
    .instructionBuffer         (instructionBuffer),
    .readInstructionCompleting (readInstructionCompleting),
    .readInstructionComplete   (readInstructionComplete),
    .busy                      (busy),
    .outOfRange                (outOfRange),
    .requestDropped            (requestDropped),
    .memAddress                (memAddress),
    .memReadEnable             (memReadEnable),
    .memData                   (memData)
  );

  instruction_rom_responder #(.ADDR_WIDTH(16), .ROM_WORDS(3), .BASE_ADDR(16'hFFF0)) dutHigh (
    .clk                       (clk),
    .reset                     (reset),
    .instructionAddress        (bInstructionAddress),
    .readInstructionStarting   (bReadInstructionStarting),
    .instructionBuffer         (bInstructionBuffer),
    .readInstructionCompleting (bReadInstructionCompleting),
    .readInstructionComplete   (bReadInstructionComplete),
    .busy                      (bBusy),
    .outOfRange                (bOutOfRange),
    .requestDropped            (bRequestDropped),
    .memAddress                (bMemAddress),
    .memReadEnable             (bMemReadEnable),
    .memData                   (bMemData)
  );

  // synchronous read ports, one cycle latency
  always @(posedge clk) begin
    if (memReadEnable)  memData  <= rom[memAddress];
    if (bMemReadEnable) bMemData <= rom[bMemAddress];
  end

  always @(negedge clk) if (readInstructionComplete) completeCount++;

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // starts a fetch in the current cycle and waits (bounded) for complete
  task automatic runFetch(input logic [31:0] idx, input logic [39:0] expWord,
                          input bit expFault, input string tag);
    int lat;
    bit done;
    bit sawCompleting;
    instructionAddress = idx;
    readInstructionStarting = 1'b1;
    tick();
    readInstructionStarting = 1'b0;
    lat = 1;
    done = 1'b0;
    sawCompleting = 1'b0;
    while (!done && lat < 20) begin
      if (readInstructionCompleting) sawCompleting = 1'b1;
      if (readInstructionComplete) done = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    checkValue({tag, " latency"}, 64'(lat), expFault ? 64'd2 : 64'd7);
    checkValue({tag, " word"}, instructionBuffer, expWord);
    checkValue({tag, " outOfRange"}, outOfRange, expFault);
    checkValue({tag, " completing seen"}, sawCompleting, !expFault);
  endtask

  initial begin
    int baseCount;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44; rom[4] = 8'h55;
    rom[5] = 8'h66; rom[6] = 8'h77; rom[7] = 8'h88; rom[8] = 8'h99; rom[9] = 8'hAA;
    rom[20475] = 8'hDE; rom[20476] = 8'hAD; rom[20477] = 8'hBE; rom[20478] = 8'hEF; rom[20479] = 8'h01;
    rom[16'hFFFA] = 8'hA1; rom[16'hFFFB] = 8'hB2; rom[16'hFFFC] = 8'hC3;
    rom[16'hFFFD] = 8'hD4; rom[16'hFFFE] = 8'hE5;

    reset = 1'b0;
    instructionAddress = '0;
    readInstructionStarting = 1'b0;
    bInstructionAddress = '0;
    bReadInstructionStarting = 1'b0;
    tick();
    tick();
    checkValue("reset buffer", instructionBuffer, 40'h0);
    checkValue("reset memAddress", memAddress, 16'h0);
    checkValue("reset strobes", {busy, memReadEnable, readInstructionComplete,
                                 readInstructionCompleting, outOfRange, requestDropped}, 6'b0);
    reset = 1'b1;
    tick();

    // index 0: address sequence, completing at T+6, complete at T+7
    instructionAddress = 32'd0;
    readInstructionStarting = 1'b1;
    tick();
    readInstructionStarting = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkValue($sformatf("fetch0 addr T+%0d", k + 1), memAddress, 64'(k));
      checkValue($sformatf("fetch0 rden T+%0d", k + 1), {memReadEnable, busy}, 2'b11);
      tick();
    end
    checkValue("fetch0 completing T+6", readInstructionCompleting, 1'b1);
    checkValue("fetch0 rden off T+6", memReadEnable, 1'b0);
    checkValue("fetch0 no partial T+6", instructionBuffer, 40'h0);
    tick();
    checkValue("fetch0 complete T+7", {readInstructionComplete, busy}, 2'b10);
    checkValue("fetch0 word", instructionBuffer, 40'h1122334455);

    // index 1 started in the DONE cycle of index 0
    runFetch(32'd1, 40'h66778899AA, 1'b0, "fetch1 b2b");

    // last valid index and out-of-range indices
    runFetch(32'd4095, 40'hDEADBEEF01, 1'b0, "fetch4095");
    instructionAddress = 32'd4096;
    readInstructionStarting = 1'b1;
    tick();
    readInstructionStarting = 1'b0;
    checkValue("fault T+1 no read", {memReadEnable, busy, readInstructionComplete}, 3'b010);
    checkValue("fault addr held", memAddress, 16'd20479);
    tick();
    checkValue("fault T+2", {readInstructionComplete, outOfRange, readInstructionCompleting}, 3'b110);
    checkValue("fault word", instructionBuffer, 40'h0);
    runFetch(32'h8000_0000, 40'h0, 1'b1, "fault bit31");
    tick();

    // start while busy is dropped and does not disturb the fetch
    instructionAddress = 32'd0;
    readInstructionStarting = 1'b1;
    tick();
    readInstructionStarting = 1'b0;
    tick();
    tick();
    checkValue("drop none yet", requestDropped, 1'b0);
    instructionAddress = 32'd2;
    readInstructionStarting = 1'b1;
    tick();
    readInstructionStarting = 1'b0;
    checkValue("drop pulse T+4", {requestDropped, busy}, 2'b11);
    tick();
    checkValue("drop one cycle T+5", requestDropped, 1'b0);
    tick();
    tick();
    checkValue("drop fetch complete T+7", readInstructionComplete, 1'b1);
    checkValue("drop fetch word", instructionBuffer, 40'h1122334455);
    tick();

    // reset mid-fetch abandons it
    instructionAddress = 32'd1;
    readInstructionStarting = 1'b1;
    tick();
    readInstructionStarting = 1'b0;
    tick();
    tick();
    tick();
    baseCount = completeCount;
    reset = 1'b0;
    tick();
    checkValue("midreset buffer", instructionBuffer, 40'h0);
    checkValue("midreset memAddress", memAddress, 16'h0);
    checkValue("midreset strobes", {busy, memReadEnable, readInstructionComplete,
                                    readInstructionCompleting, outOfRange, requestDropped}, 6'b0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkValue("midreset no complete", 64'(completeCount - baseCount), 64'd0);
    runFetch(32'd1, 40'h66778899AA, 1'b0, "after reset");

    // high-base instance: index 2 at FFFA..FFFE, index 3 out of range
    bInstructionAddress = 32'd2;
    bReadInstructionStarting = 1'b1;
    tick();
    bReadInstructionStarting = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkValue($sformatf("high addr T+%0d", k + 1), bMemAddress, 64'(16'hFFFA + k));
      tick();
    end
    checkValue("high completing", bReadInstructionCompleting, 1'b1);
    tick();
    checkValue("high complete", {bReadInstructionComplete, bOutOfRange}, 2'b10);
    checkValue("high word", bInstructionBuffer, 40'hA1B2C3D4E5);
    bInstructionAddress = 32'd3;
    bReadInstructionStarting = 1'b1;
    tick();
    bReadInstructionStarting = 1'b0;
    tick();
    checkValue("high fault", {bReadInstructionComplete, bOutOfRange}, 2'b11);
    checkValue("high fault word", bInstructionBuffer, 40'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
